// File: rtl/op_lut_event_cntr_bank_pkg.sv
// Shared definitions for the output-port-lookup event counter bank:
// ring field widths, the bad-address read pattern, per-instance block
// tags and the index map of the lookup counters.
package op_lut_event_cntr_bank_pkg;

  localparam int UDP_REG_ADDR_WIDTH  = 23;
  localparam int CPCI_NF2_DATA_WIDTH = 32;

  // Returned for any ring access that hits this block but names no counter
  localparam logic [31:0] BAD_ADDR_DATA = 32'hDEAD_BEEF;

  // Address tags of the counter banks instantiated in the router
  localparam int OP_LUT_CNTR_BLOCK_TAG    = 17'h0_0010;
  localparam int IN_ARB_CNTR_BLOCK_TAG    = 17'h0_0011;
  localparam int OUT_QUEUE_CNTR_BLOCK_TAG = 17'h0_0012;

  // Counter index map of the output-port lookup
  typedef enum int {
    IDX_ARP_MISS      = 0,
    IDX_LPM_MISS      = 1,
    IDX_FILTER_HIT    = 2,
    IDX_WRONG_DEST    = 3,
    IDX_PKT_FORWARDED = 4,
    IDX_BAD_OPTS_VER  = 5,
    IDX_BAD_CHKSUM    = 6,
    IDX_BAD_TTL       = 7,
    IDX_NON_IP_RCVD   = 8,
    IDX_PKT_DROPPED   = 9,
    NUM_OP_LUT_CNTRS  = 10
  } op_lut_cntr_idx_e;

endpackage

// File: rtl/op_lut_event_cntr_bank_slice.sv
// One event counter of the bank. A ring write loads it, a clear-on-read
// zeroes it, and the event of the same cycle is always added on top, so
// a coincident event is never lost. Optional saturation at all-ones.
module op_lut_cntr_slice #(
  parameter int CNTR_WIDTH = 32,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_event,
  input  logic                  i_ld,
  input  logic [CNTR_WIDTH-1:0] i_ld_val,
  input  logic                  i_clr,
  output logic [CNTR_WIDTH-1:0] o_cnt
);

  logic [CNTR_WIDTH-1:0] r_cnt;
  logic [CNTR_WIDTH-1:0] w_base;
  logic [CNTR_WIDTH-1:0] w_next;

  // Pick the starting value (load, clear or current), then add the event
  always_comb begin
    w_base = r_cnt;
    if (i_ld) begin
      w_base = i_ld_val;
    end else if (i_clr) begin
      w_base = '0;
    end
    w_next = w_base + CNTR_WIDTH'(i_event);
    if ((SATURATE != 0) && (&w_base)) begin
      w_next = w_base;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/op_lut_event_cntr_bank.sv
// Parametrised event counter bank sitting in series on the UDP register
// ring. Decodes ring requests aimed at this block, serves reads and writes
// of the counters, and forwards everything through a one-cycle register
// stage.
module op_lut_event_cntr_bank
  import op_lut_event_cntr_bank_pkg::*;
#(
  parameter int NUM_CNTRS         = 10,
  parameter int CNTR_WIDTH        = 32,
  parameter int SATURATE          = 0,
  parameter int CLEAR_ON_READ     = 0,
  parameter int BLOCK_TAG         = 0,
  parameter int IDX_BITS          = 6,
  parameter int UDP_REG_SRC_WIDTH = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           reg_req_in,
  input  logic                           reg_ack_in,
  input  logic                           reg_rd_wr_L_in,
  input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
  input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
  input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in,
  output logic                           reg_req_out,
  output logic                           reg_ack_out,
  output logic                           reg_rd_wr_L_out,
  output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
  output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
  output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out,
  input  logic [NUM_CNTRS-1:0]           event_pulse
);

  localparam int                TAG_W      = UDP_REG_ADDR_WIDTH - IDX_BITS;
  localparam logic [TAG_W-1:0]  TAG        = TAG_W'(BLOCK_TAG);
  localparam logic [IDX_BITS:0] CNTR_LIMIT = (IDX_BITS + 1)'(NUM_CNTRS);

  logic                           w_hit;
  logic                           w_idxValid;
  logic [IDX_BITS-1:0]            w_idx;
  logic [NUM_CNTRS-1:0]           w_ld;
  logic [NUM_CNTRS-1:0]           w_clr;
  logic [CNTR_WIDTH-1:0]          w_cnt [NUM_CNTRS];
  logic [CNTR_WIDTH-1:0]          w_rdCnt;
  logic [CPCI_NF2_DATA_WIDTH-1:0] w_rdData;
  logic [CPCI_NF2_DATA_WIDTH-1:0] w_dataNext;

  logic                           r_req;
  logic                           r_ack;
  logic                           r_rdWrL;
  logic [UDP_REG_ADDR_WIDTH-1:0]  r_addr;
  logic [CPCI_NF2_DATA_WIDTH-1:0] r_data;
  logic [UDP_REG_SRC_WIDTH-1:0]   r_src;

  assign w_idx      = reg_addr_in[IDX_BITS-1:0];
  assign w_hit      = reg_req_in & ~reg_ack_in &
                      (reg_addr_in[UDP_REG_ADDR_WIDTH-1:IDX_BITS] == TAG);
  assign w_idxValid = ({1'b0, w_idx} < CNTR_LIMIT);

  // Per-counter load and clear strobes from the decoded ring access
  always_comb begin
    w_ld  = '0;
    w_clr = '0;
    for (int i = 0; i < NUM_CNTRS; i++) begin
      if (w_hit && (w_idx == IDX_BITS'(i))) begin
        w_ld[i]  = ~reg_rd_wr_L_in;
        w_clr[i] = reg_rd_wr_L_in & (CLEAR_ON_READ != 0);
      end
    end
  end

  // Read mux over the counter values held before this cycle's update
  always_comb begin
    w_rdCnt = '0;
    for (int i = 0; i < NUM_CNTRS; i++) begin
      if (w_idx == IDX_BITS'(i)) begin
        w_rdCnt = w_cnt[i];
      end
    end
    w_rdData                 = '0;
    w_rdData[CNTR_WIDTH-1:0] = w_rdCnt;
  end

  // Data going onto the ring: pass-through unless this block serves a read
  // or the access names a counter that does not exist
  always_comb begin
    w_dataNext = reg_data_in;
    if (w_hit) begin
      if (!w_idxValid) begin
        w_dataNext = BAD_ADDR_DATA;
      end else if (reg_rd_wr_L_in) begin
        w_dataNext = w_rdData;
      end
    end
  end

  for (genvar g = 0; g < NUM_CNTRS; g++) begin : g_cntr
    op_lut_cntr_slice #(
      .CNTR_WIDTH (CNTR_WIDTH),
      .SATURATE   (SATURATE)
    ) u_slice (
      .clk      (clk),
      .reset    (reset),
      .i_event  (event_pulse[g]),
      .i_ld     (w_ld[g]),
      .i_ld_val (reg_data_in[CNTR_WIDTH-1:0]),
      .i_clr    (w_clr[g]),
      .o_cnt    (w_cnt[g])
    );
  end

  // One-cycle ring stage; a hit is acknowledged here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req   <= 1'b0;
      r_ack   <= 1'b0;
      r_rdWrL <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_src   <= '0;
    end else begin
      r_req   <= reg_req_in;
      r_ack   <= reg_ack_in | w_hit;
      r_rdWrL <= reg_rd_wr_L_in;
      r_addr  <= reg_addr_in;
      r_data  <= w_dataNext;
      r_src   <= reg_src_in;
    end
  end

  assign reg_req_out     = r_req;
  assign reg_ack_out     = r_ack;
  assign reg_rd_wr_L_out = r_rdWrL;
  assign reg_addr_out    = r_addr;
  assign reg_data_out    = r_data;
  assign reg_src_out     = r_src;

endmodule

// File: tb/tb_op_lut_event_cntr_bank.sv
// Testbench for the event counter bank. Four instances share one ring
// input and one event bus: a default bank, 4-bit wrapping and saturating
// banks, and a clear-on-read bank.
module tb_op_lut_event_cntr_bank;

  localparam int AW = 23;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int NC = 10;

  localparam int MAIN = 0;
  localparam int WRAP = 1;
  localparam int SAT  = 2;
  localparam int COR  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          reqIn;
  logic          ackIn;
  logic          rdWrLIn;
  logic [AW-1:0] addrIn;
  logic [DW-1:0] dataIn;
  logic [SW-1:0] srcIn;
  logic [NC-1:0] eventPulse;

  logic          reqOut   [4];
  logic          ackOut   [4];
  logic          rdWrLOut [4];
  logic [AW-1:0] addrOut  [4];
  logic [DW-1:0] dataOut  [4];
  logic [SW-1:0] srcOut   [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         name;
    logic          req;
    logic          ack;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] src;
    logic [NC-1:0] pulse;
    logic          expAck;
    logic [DW-1:0] expData;
  } vec_t;

  vec_t vecQ[$];

  always #5 clk = ~clk;

  op_lut_event_cntr_bank #(.NUM_CNTRS(NC), .CNTR_WIDTH(32), .SATURATE(0), .CLEAR_ON_READ(0)) u_main (
    .clk(clk), .reset(reset),
    .reg_req_in(reqIn), .reg_ack_in(ackIn), .reg_rd_wr_L_in(rdWrLIn),
    .reg_addr_in(addrIn), .reg_data_in(dataIn), .reg_src_in(srcIn),
    .reg_req_out(reqOut[MAIN]), .reg_ack_out(ackOut[MAIN]), .reg_rd_wr_L_out(rdWrLOut[MAIN]),
    .reg_addr_out(addrOut[MAIN]), .reg_data_out(dataOut[MAIN]), .reg_src_out(srcOut[MAIN]),
    .event_pulse(eventPulse)
  );

  op_lut_event_cntr_bank #(.NUM_CNTRS(NC), .CNTR_WIDTH(4), .SATURATE(0), .CLEAR_ON_READ(0)) u_wrap (
    .clk(clk), .reset(reset),
    .reg_req_in(reqIn), .reg_ack_in(ackIn), .reg_rd_wr_L_in(rdWrLIn),
    .reg_addr_in(addrIn), .reg_data_in(dataIn), .reg_src_in(srcIn),
    .reg_req_out(reqOut[WRAP]), .reg_ack_out(ackOut[WRAP]), .reg_rd_wr_L_out(rdWrLOut[WRAP]),
    .reg_addr_out(addrOut[WRAP]), .reg_data_out(dataOut[WRAP]), .reg_src_out(srcOut[WRAP]),
    .event_pulse(eventPulse)
  );

  op_lut_event_cntr_bank #(.NUM_CNTRS(NC), .CNTR_WIDTH(4), .SATURATE(1), .CLEAR_ON_READ(0)) u_sat (
    .clk(clk), .reset(reset),
    .reg_req_in(reqIn), .reg_ack_in(ackIn), .reg_rd_wr_L_in(rdWrLIn),
    .reg_addr_in(addrIn), .reg_data_in(dataIn), .reg_src_in(srcIn),
    .reg_req_out(reqOut[SAT]), .reg_ack_out(ackOut[SAT]), .reg_rd_wr_L_out(rdWrLOut[SAT]),
    .reg_addr_out(addrOut[SAT]), .reg_data_out(dataOut[SAT]), .reg_src_out(srcOut[SAT]),
    .event_pulse(eventPulse)
  );

  op_lut_event_cntr_bank #(.NUM_CNTRS(NC), .CNTR_WIDTH(32), .SATURATE(0), .CLEAR_ON_READ(1)) u_cor (
    .clk(clk), .reset(reset),
    .reg_req_in(reqIn), .reg_ack_in(ackIn), .reg_rd_wr_L_in(rdWrLIn),
    .reg_addr_in(addrIn), .reg_data_in(dataIn), .reg_src_in(srcIn),
    .reg_req_out(reqOut[COR]), .reg_ack_out(ackOut[COR]), .reg_rd_wr_L_out(rdWrLOut[COR]),
    .reg_addr_out(addrOut[COR]), .reg_data_out(dataOut[COR]), .reg_src_out(srcOut[COR]),
    .event_pulse(eventPulse)
  );

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle of ring and event inputs, then sample just after the edge
  task automatic applyStimulus(input logic req, input logic ack, input logic rd,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [SW-1:0] src, input logic [NC-1:0] pulse);
    reqIn      = req;
    ackIn      = ack;
    rdWrLIn    = rd;
    addrIn     = addr;
    dataIn     = data;
    srcIn      = src;
    eventPulse = pulse;
    @(posedge clk);
    #1;
  endtask

  task automatic readIdx(input int idx, input logic [NC-1:0] pulse);
    applyStimulus(1'b1, 1'b0, 1'b1, AW'(idx), 32'h0, 2'd0, pulse);
  endtask

  task automatic writeIdx(input int idx, input logic [DW-1:0] data, input logic [NC-1:0] pulse);
    applyStimulus(1'b1, 1'b0, 1'b0, AW'(idx), data, 2'd0, pulse);
  endtask

  task automatic pulseOnly(input logic [NC-1:0] pulse);
    applyStimulus(1'b0, 1'b0, 1'b1, AW'(0), 32'h0, 2'd0, pulse);
  endtask

  task automatic addVec(input string name, input logic req, input logic ack, input logic rd,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] src,
                        input logic [NC-1:0] pulse, input logic expAck, input logic [DW-1:0] expData);
    vec_t v;
    v.name    = name;
    v.req     = req;
    v.ack     = ack;
    v.rd      = rd;
    v.addr    = addr;
    v.data    = data;
    v.src     = src;
    v.pulse   = pulse;
    v.expAck  = expAck;
    v.expData = expData;
    vecQ.push_back(v);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Vector table: counting, write with coincident event, pass-through and bad index
    addVec("cnt_c0",     0, 0, 1, 23'h000000, 32'h0,         2'd0, 10'h009, 0, 32'h0);
    addVec("cnt_c1",     0, 0, 1, 23'h000000, 32'h0,         2'd0, 10'h009, 0, 32'h0);
    addVec("cnt_c2",     0, 0, 1, 23'h000000, 32'h0,         2'd0, 10'h008, 0, 32'h0);
    addVec("cnt_c3",     0, 0, 1, 23'h000000, 32'h0,         2'd0, 10'h008, 0, 32'h0);
    addVec("cnt_c4",     0, 0, 1, 23'h000000, 32'h0,         2'd0, 10'h008, 0, 32'h0);
    addVec("rd_idx3",    1, 0, 1, 23'h000003, 32'h0,         2'd1, 10'h000, 1, 32'd5);
    addVec("rd_idx0",    1, 0, 1, 23'h000000, 32'h0,         2'd2, 10'h000, 1, 32'd2);
    addVec("rd_idx4",    1, 0, 1, 23'h000004, 32'h0,         2'd3, 10'h000, 1, 32'd0);
    addVec("wr_idx5",    1, 0, 0, 23'h000005, 32'd100,       2'd1, 10'h020, 1, 32'd100);
    addVec("rd_idx5",    1, 0, 1, 23'h000005, 32'h0,         2'd0, 10'h000, 1, 32'd101);
    addVec("tag_miss_r", 1, 0, 1, 23'h000043, 32'h1234_5678, 2'd2, 10'h000, 0, 32'h1234_5678);
    addVec("acked_wr3",  1, 1, 0, 23'h000003, 32'h0000_0055, 2'd1, 10'h000, 1, 32'h0000_0055);
    addVec("rd_idx3_b",  1, 0, 1, 23'h000003, 32'h0,         2'd0, 10'h000, 1, 32'd5);
    addVec("rd_idx10",   1, 0, 1, 23'h00000A, 32'h0,         2'd0, 10'h000, 1, 32'hDEAD_BEEF);
    addVec("wr_idx10",   1, 0, 0, 23'h00000A, 32'h0000_0099, 2'd0, 10'h000, 1, 32'hDEAD_BEEF);
    addVec("rd_idx63",   1, 0, 1, 23'h00003F, 32'h0,         2'd3, 10'h000, 1, 32'hDEAD_BEEF);
    addVec("tag_miss_w", 1, 0, 0, 23'h7FFFC5, 32'h0000_0077, 2'd1, 10'h000, 0, 32'h0000_0077);
    addVec("rd_idx5_b",  1, 0, 1, 23'h000005, 32'h0,         2'd0, 10'h000, 1, 32'd101);

    // Reset state while reset is held
    reset      = 1'b1;
    reqIn      = 1'b0;
    ackIn      = 1'b0;
    rdWrLIn    = 1'b0;
    addrIn     = '0;
    dataIn     = '0;
    srcIn      = '0;
    eventPulse = '0;
    #12;
    checkOutput("rst_ack",  32'(ackOut[MAIN]),  32'h0);
    checkOutput("rst_req",  32'(reqOut[MAIN]),  32'h0);
    checkOutput("rst_data", dataOut[MAIN],      32'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Every counter reads zero after reset; ack one clock after each request
    for (int i = 0; i < NC; i++) begin
      readIdx(i, '0);
      checkOutput($sformatf("rst_rd%0d_ack", i), 32'(ackOut[MAIN]), 32'h1);
      checkOutput($sformatf("rst_rd%0d_data", i), dataOut[MAIN], 32'h0);
    end
    checkOutput("rst_rd9_addr", 32'(addrOut[MAIN]), 32'd9);
    pulseOnly('0);
    checkOutput("ack_one_cycle", 32'(ackOut[MAIN]), 32'h0);

    // Table-driven vectors
    foreach (vecQ[k]) begin
      applyStimulus(vecQ[k].req, vecQ[k].ack, vecQ[k].rd, vecQ[k].addr,
                    vecQ[k].data, vecQ[k].src, vecQ[k].pulse);
      checkOutput({vecQ[k].name, ".ack"},  32'(ackOut[MAIN]),   32'(vecQ[k].expAck));
      checkOutput({vecQ[k].name, ".data"}, dataOut[MAIN],       vecQ[k].expData);
      checkOutput({vecQ[k].name, ".req"},  32'(reqOut[MAIN]),   32'(vecQ[k].req));
      checkOutput({vecQ[k].name, ".rd"},   32'(rdWrLOut[MAIN]), 32'(vecQ[k].rd));
      checkOutput({vecQ[k].name, ".addr"}, 32'(addrOut[MAIN]),  32'(vecQ[k].addr));
      checkOutput({vecQ[k].name, ".src"},  32'(srcOut[MAIN]),   32'(vecQ[k].src));
    end

    // Wrap versus saturate near all-ones; upper write data bits ignored
    writeIdx(1, 32'hFFFF_FFFE, '0);
    checkOutput("wrsat_wr_echo", dataOut[MAIN], 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) pulseOnly(10'h002);
    readIdx(1, '0);
    checkOutput("wrap4_idx1",  dataOut[WRAP], 32'h1);
    checkOutput("sat4_idx1",   dataOut[SAT],  32'hF);
    checkOutput("wrap32_idx1", dataOut[MAIN], 32'h1);

    // Write all-ones together with an event
    writeIdx(6, 32'h0000_000F, 10'h040);
    readIdx(6, '0);
    checkOutput("sat4_wr_ev",  dataOut[SAT],  32'hF);
    checkOutput("wrap4_wr_ev", dataOut[WRAP], 32'h0);
    checkOutput("main_wr_ev",  dataOut[MAIN], 32'h10);

    // Clear-on-read with a coincident event
    writeIdx(2, 32'd7, '0);
    readIdx(2, 10'h004);
    checkOutput("cor_rd1",  dataOut[COR],  32'd7);
    checkOutput("main_rd1", dataOut[MAIN], 32'd7);
    readIdx(2, '0);
    checkOutput("cor_rd2",  dataOut[COR],  32'd1);
    checkOutput("main_rd2", dataOut[MAIN], 32'd8);
    readIdx(2, '0);
    checkOutput("cor_rd3",  dataOut[COR],  32'd0);
    checkOutput("main_rd3", dataOut[MAIN], 32'd8);

    // Every counter increments in the same cycle
    pulseOnly(10'h3FF);
    pulseOnly(10'h3FF);
    readIdx(7, '0);
    checkOutput("all_idx7", dataOut[MAIN], 32'd2);
    readIdx(3, '0);
    checkOutput("all_idx3", dataOut[MAIN], 32'd7);
    readIdx(0, '0);
    checkOutput("all_idx0", dataOut[MAIN], 32'd4);
    readIdx(9, '0);
    checkOutput("all_idx9", dataOut[MAIN], 32'd2);
    readIdx(6, '0);
    checkOutput("all_sat_idx6",  dataOut[SAT],  32'hF);
    checkOutput("all_wrap_idx6", dataOut[WRAP], 32'h2);
    checkOutput("all_main_idx6", dataOut[MAIN], 32'h12);

    // Asynchronous reset in the middle of a served request
    applyStimulus(1'b1, 1'b0, 1'b1, AW'(3), 32'hA5A5_A5A5, 2'd3, '0);
    checkOutput("pre_rst_ack", 32'(ackOut[MAIN]), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("arst_req",  32'(reqOut[MAIN]),   32'h0);
    checkOutput("arst_ack",  32'(ackOut[MAIN]),   32'h0);
    checkOutput("arst_rd",   32'(rdWrLOut[MAIN]), 32'h0);
    checkOutput("arst_addr", 32'(addrOut[MAIN]),  32'h0);
    checkOutput("arst_data", dataOut[MAIN],       32'h0);
    checkOutput("arst_src",  32'(srcOut[MAIN]),   32'h0);
    reqIn      = 1'b0;
    eventPulse = 10'h080;
    @(posedge clk);
    #1;
    reset = 1'b0;
    readIdx(7, '0);
    checkOutput("post_rst_idx7", dataOut[MAIN], 32'd0);
    readIdx(3, '0);
    checkOutput("post_rst_idx3", dataOut[MAIN], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
